// File: rtl/spi_display_tx.sv
// Byte-wide SPI mode-0 transmitter for a display panel with a data/command line.
// Define SPI_DISPLAY_TX_FIFO_EN to add a 4-entry request FIFO in front of the shifter.
module spi_display_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_start,
    input  logic [7:0] spi_data_in,
    input  logic       spi_dc,
    output logic       spi_busy,
    output logic       spi_done,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       dc
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned WORD_W = 9;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [7:0]         shreg, shreg_n;
    logic               sclk_n, mosi_n, cs_n_n, dc_n, busy_n, done_n;

    // Request staging: q_head is the {dc, data} word the next transfer starts from
    logic               q_push, q_pop, q_valid, q_queued_n;
    logic [WORD_W-1:0]  q_head;

    assign q_pop = (state == IDLE) && q_valid;

`ifdef SPI_DISPLAY_TX_FIFO_EN
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned FCNT_W     = 3;

    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt, fifo_cnt_n;

    assign q_push  = spi_start && (fifo_cnt != FCNT_W'(FIFO_DEPTH));
    assign q_valid = (fifo_cnt != '0);
    assign q_head  = fifo_mem[rd_ptr];

    always_comb begin
        fifo_cnt_n = fifo_cnt;
        case ({q_push, q_pop})
            2'b10:   fifo_cnt_n = fifo_cnt + FCNT_W'(1);
            2'b01:   fifo_cnt_n = fifo_cnt - FCNT_W'(1);
            default: fifo_cnt_n = fifo_cnt;
        endcase
    end

    assign q_queued_n = (fifo_cnt_n != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (q_push) begin
                fifo_mem[wr_ptr] <= {spi_dc, spi_data_in};
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt_n;
        end
    end
`else
    // Single holding slot; requests arriving while a transfer is pending or active are ignored
    logic              pend_valid;
    logic [WORD_W-1:0] pend_word;

    assign q_push     = spi_start && (state == IDLE) && !pend_valid;
    assign q_valid    = pend_valid;
    assign q_head     = pend_word;
    assign q_queued_n = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_word  <= '0;
        end else if (q_push) begin
            pend_valid <= 1'b1;
            pend_word  <= {spi_dc, spi_data_in};
        end else if (q_pop) begin
            pend_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            dc       <= 1'b0;
            spi_busy <= 1'b0;
            spi_done <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            sclk     <= sclk_n;
            mosi     <= mosi_n;
            cs_n     <= cs_n_n;
            dc       <= dc_n;
            spi_busy <= busy_n;
            spi_done <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        sclk_n    = sclk;
        mosi_n    = mosi;
        cs_n_n    = cs_n;
        dc_n      = dc;
        done_n    = spi_done;

        if (q_push) begin
            done_n = 1'b0;
        end

        case (state)
            IDLE: begin
                cs_n_n    = 1'b1;
                sclk_n    = 1'b0;
                mosi_n    = 1'b0;
                cnt_n     = '0;
                bit_cnt_n = '0;
                if (q_pop) begin
                    state_n = SETUP;
                    shreg_n = q_head[7:0];
                    dc_n    = q_head[8];
                    mosi_n  = q_head[7];
                    cs_n_n  = 1'b0;
                end
            end
            SETUP: begin
                if (cnt == DIV_LAST) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    sclk_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            // Falling edge shifts the next bit out; the 8th low phase hands over to HOLD
            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_n = '0;
                    if (sclk) begin
                        sclk_n  = 1'b0;
                        shreg_n = {shreg[6:0], 1'b0};
                        mosi_n  = shreg[6];
                    end else if (bit_cnt == BIT_W'(7)) begin
                        state_n = HOLD;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                        sclk_n    = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == DIV_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    cs_n_n  = 1'b1;
                    mosi_n  = 1'b0;
                    if (!q_queued_n) begin
                        done_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE) || q_queued_n;
    end

endmodule
